// File: rtl/mem_bus_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_bus_pkg                                                          |
// | Shared widths, state encodings and op encoding for mem_bus_arbiter.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package mem_bus_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 16;

  localparam logic [2:0] QIdle    = 3'b001;
  localparam logic [2:0] QBusy    = 3'b010;
  localparam logic [2:0] QRelease = 3'b100;

  typedef enum logic [2:0] {
    ST_IDLE    = QIdle,
    ST_BUSY    = QBusy,
    ST_RELEASE = QRelease
  } state_e;

  localparam logic OP_RD = 1'b0;
  localparam logic OP_WR = 1'b1;

  function automatic logic [1:0] onehot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_bus_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_bus_arbiter_if                                                   |
// | Two cache-side requester buses plus the Memory-side bus.             |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface mem_bus_arbiter_if #(
  parameter int ADDR_W = mem_bus_pkg::ADDR_W,
  parameter int DATA_W = mem_bus_pkg::DATA_W
);
  import mem_bus_pkg::*;

  logic              r0_rd;
  logic              r0_wr;
  logic [ADDR_W-1:0] r0_addr;
  logic [DATA_W-1:0] r0_wdata;
  logic [DATA_W-1:0] r0_rdata;
  logic              r0_done;

  logic              r1_rd;
  logic              r1_wr;
  logic [ADDR_W-1:0] r1_addr;
  logic [DATA_W-1:0] r1_wdata;
  logic [DATA_W-1:0] r1_rdata;
  logic              r1_done;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_read;
  logic              mem_write;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_done;

  logic [1:0]        grant;
  logic              proto_err;

  // slave: the arbiter itself; master: the caches and Memory around it
  modport slave (
    input  r0_rd, r0_wr, r0_addr, r0_wdata,
    output r0_rdata, r0_done,
    input  r1_rd, r1_wr, r1_addr, r1_wdata,
    output r1_rdata, r1_done,
    output mem_addr, mem_read, mem_write, mem_wdata,
    input  mem_rdata, mem_done,
    output grant, proto_err
  );

  modport master (
    output r0_rd, r0_wr, r0_addr, r0_wdata,
    input  r0_rdata, r0_done,
    output r1_rd, r1_wr, r1_addr, r1_wdata,
    input  r1_rdata, r1_done,
    input  mem_addr, mem_read, mem_write, mem_wdata,
    output mem_rdata, mem_done,
    input  grant, proto_err
  );

endinterface
`default_nettype wire

// File: rtl/mem_bus_arbiter_rr_pick2.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_pick2                                                             |
// | Combinational 2-way round-robin picker; on a tie, !last wins.        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module rr_pick2 (
  input  wire logic [1:0] req,
  input  wire logic       last,
  output logic            winner,
  output logic            valid
);
  import mem_bus_pkg::*;

  always_comb begin
    valid  = |req;
    winner = 1'b0;
    if (req == 2'b11) begin
      winner = ~last;
    end else begin
      winner = req[1];
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_bus_arbiter                                                      |
// | Round-robin sharing of one Memory between two cache requesters.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module mem_bus_arbiter #(
  parameter int ADDR_W = mem_bus_pkg::ADDR_W,
  parameter int DATA_W = mem_bus_pkg::DATA_W
) (
  input  wire logic      clk,
  input  wire logic      rst,
  mem_bus_arbiter_if.slave bus
);
  import mem_bus_pkg::*;

  state_e            state_q, state_d;
  logic [1:0]        grant_q, grant_d;
  logic              last_q, last_d;
  logic              op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              proto_err_q, proto_err_d;

  logic [1:0]        req;
  logic              winner;
  logic              pick_valid;
  logic              w_rd;
  logic              w_wr;
  logic              busy;

  assign req = {bus.r1_rd | bus.r1_wr, bus.r0_rd | bus.r0_wr};

  rr_pick2 u_pick (
    .req    (req),
    .last   (last_q),
    .winner (winner),
    .valid  (pick_valid)
  );

  assign w_rd = winner ? bus.r1_rd : bus.r0_rd;
  assign w_wr = winner ? bus.r1_wr : bus.r0_wr;

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    last_d      = last_q;
    op_d        = op_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    proto_err_d = proto_err_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          addr_d  = winner ? bus.r1_addr  : bus.r0_addr;
          wdata_d = winner ? bus.r1_wdata : bus.r0_wdata;
          // a simultaneous rd+wr is served as the write and flagged
          op_d    = w_wr ? OP_WR : OP_RD;
          grant_d = onehot2(winner);
          last_d  = winner;
          state_d = ST_BUSY;
          if (w_rd && w_wr) begin
            proto_err_d = 1'b1;
          end
        end
      end
      ST_BUSY: begin
        if (bus.mem_done) begin
          grant_d = 2'b00;
          state_d = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        state_d = ST_IDLE;
      end
      default: begin
        grant_d = 2'b00;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      grant_q     <= 2'b00;
      last_q      <= 1'b1;
      op_q        <= OP_RD;
      addr_q      <= '0;
      wdata_q     <= '0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      last_q      <= last_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      proto_err_q <= proto_err_d;
    end
  end

  // strobes follow the registered state, so they drop on the mem_done edge
  assign busy          = (state_q == ST_BUSY);
  assign bus.mem_read  = busy & (op_q == OP_RD);
  assign bus.mem_write = busy & (op_q == OP_WR);
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;

  assign bus.r0_done   = bus.mem_done & grant_q[0] & busy;
  assign bus.r1_done   = bus.mem_done & grant_q[1] & busy;
  assign bus.r0_rdata  = bus.mem_rdata;
  assign bus.r1_rdata  = bus.mem_rdata;

  assign bus.grant     = grant_q;
  assign bus.proto_err = proto_err_q;

endmodule
`default_nettype wire
